lsu_arbiter: RTL and testbench
==============================

# lsu_arbiter

Shares the single UART-backed load/store unit between the instruction-fetch requester (IF, load-only) and the execute-stage data requester (LS, load or store). It latches one request at a time and drives the load/store unit's enable/address/store-data inputs. It waits for the unit's done pulse, then returns read data and a one-cycle acknowledge to the winning requester. Arbitration is round-robin on ties, and a watchdog flags transactions that never complete.

## Interface

Parameters:
- TIMEOUT_CYCLES, 4096: cycles in GRANT without lsu_done before err is raised (16-bit counter).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low.
- if_req  in  1  IF request; held high until if_ack.
- if_addr  in  8  IF word address; sampled at grant.
- if_rdata  out  16  IF read data; valid in the if_ack cycle, held until the next IF grant.
- if_ack  out  1  one-cycle completion pulse to IF.
- ls_req  in  1  LS request; held high until ls_ack.
- ls_we  in  1  1 = store, 0 = load; sampled at grant.
- ls_addr  in  8  LS address; sampled at grant.
- ls_wdata  in  16  LS store data; sampled at grant.
- ls_rdata  out  16  LS load data; valid in the ls_ack cycle, held until the next LS load grant.
- ls_ack  out  1  one-cycle completion pulse to LS.
- lsu_en  out  2  to the load/store unit: 00 idle, 01 load, 10 store; never 11.
- lsu_addr  out  8  latched address to the unit.
- lsu_wdata  out  16  latched store data to the unit.
- lsu_rdata  in  16  load data from the unit; valid while lsu_done=1.
- lsu_done  in  1  unit completion, one-cycle pulse.
- busy  out  1  high in GRANT and RESP.
- err  out  1  sticky watchdog flag; cleared only by reset.

## Operation

- The FSM has three states: IDLE, GRANT, RESP. The state and all outputs are registered; lsu_en is decoded from the registered state plus the latched op only.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester other than last_grant.
  - On grant, latch the owner, op (IF is always load), address and wdata (IF wdata = 0). Update last_grant, clear the watchdog counter, and go to GRANT.
- GRANT:
  - lsu_en = 01 for a load, 10 for a store. lsu_addr and lsu_wdata come from the latches and are stable for the whole state.
  - Request inputs are ignored in this state.
  - On lsu_done=1, if the op is a load, capture lsu_rdata into the owner's rdata register; then go to RESP.
  - Otherwise increment the counter, which saturates. When the counter reaches TIMEOUT_CYCLES, set err and keep waiting; there is no abort.
- RESP:
  - lsu_en = 00.
  - Pulse the owner's ack for exactly this cycle.
  - Go to IDLE.
- lsu_en must read 00 in the cycle after lsu_done. The unit returns to its flag-send state that cycle and would start a spurious transaction on a non-zero enable. RESP guarantees this.
- A store does not modify either rdata register.
- Reset to IDLE. Outputs at reset:
  - lsu_en=00, lsu_addr=0, lsu_wdata=0.
  - if_ack=0, ls_ack=0, if_rdata=0, ls_rdata=0.
  - busy=0, err=0.
  - last_grant=IF, so the first tie goes to LS.
- Reset asserted mid-transaction abandons it with no ack.
- lsu_done outside GRANT is ignored.

## Timing

- Request high at edge k (sampled in IDLE): GRANT from k+1, with lsu_en valid in cycle k+1.
- lsu_done seen at edge n: RESP in cycle n+1, with ack=1 and rdata valid; IDLE at n+2.
- Earliest next grant is at edge n+2, making GRANT n+3. Between transactions lsu_en is therefore 00 for at least 2 cycles.
- Ack-to-data: rdata is updated on the same edge on which ack rises.
- A request deasserted before grant is simply not served. A request deasserted during GRANT does not cancel the transaction.
- Watchdog: err rises on the edge where the counter reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after entering GRANT.

## Test plan

- IF-only load, addr 0x12: lsu_en=01 and lsu_addr=0x12 one cycle after if_req. After lsu_done with lsu_rdata=0xBEEF: if_ack pulses one cycle later, if_rdata=0xBEEF, ls_ack stays 0.
- LS store, addr 0x40, wdata 0xA5C3: lsu_en=10, lsu_wdata=0xA5C3 through GRANT. After done: ls_ack=1 for one cycle, and ls_rdata and if_rdata are unchanged.
- Both requests held continuously after reset: grants alternate LS, IF, LS, IF. Each transaction gives exactly one ack, and lsu_en is 00 for at least 2 cycles between grants.
- lsu_done pulse while in IDLE: no state change, no ack.
- TIMEOUT_CYCLES=8 with no lsu_done: err=1 on the 8th GRANT cycle and lsu_en stays 01. A later lsu_done still completes with ack, and err stays 1 until reset.
- Reset low during GRANT: next cycle lsu_en=00, busy=0, no ack, and all outputs at their reset values.

Source files
------------

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin sharing of the load/store unit between IF and LS, with a sticky watchdog.
module lsu_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [7:0]  ls_addr,
  input  logic [15:0] ls_wdata,
  output logic [15:0] ls_rdata,
  output logic        ls_ack,
  output logic [1:0]  lsu_en,
  output logic [7:0]  lsu_addr,
  output logic [15:0] lsu_wdata,
  input  logic [15:0] lsu_rdata,
  input  logic        lsu_done,
  output logic        busy,
  output logic        err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);
  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] ls_rdata_q, ls_rdata_d;
  logic        pick_ls;
  // owner/last encoding: 0 = IF, 1 = LS; on a tie the side that did not win last time goes
  assign pick_ls = ls_req && (!if_req || !last_q);
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    last_d     = last_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if (state_q == IDLE) begin
      if (if_req || ls_req) begin
        state_d = GRANT;
        owner_d = pick_ls;
        we_d    = pick_ls && ls_we;
        addr_d  = pick_ls ? ls_addr : if_addr;
        wdata_d = pick_ls ? ls_wdata : 16'h0000;
        last_d  = pick_ls;
        cnt_d   = 16'h0000;
      end
    end else if (state_q == GRANT) begin
      if (lsu_done) begin
        state_d    = RESP;
        if_rdata_d = (!we_q && !owner_q) ? lsu_rdata : if_rdata_q;
        ls_rdata_d = (!we_q && owner_q) ? lsu_rdata : ls_rdata_q;
      end else begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        err_d = err_q || (cnt_d == TIMEOUT);
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 16'h0000;
      cnt_q      <= 16'h0000;
      if_rdata_q <= 16'h0000;
      ls_rdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      last_q     <= last_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end
  // enable is forced to 00 outside GRANT, so the cycle after lsu_done (RESP) is always quiet
  assign lsu_en    = (state_q == GRANT) ? (we_q ? 2'b10 : 2'b01) : 2'b00;
  assign lsu_addr  = addr_q;
  assign lsu_wdata = wdata_q;
  assign if_ack    = (state_q == RESP) && !owner_q;
  assign ls_ack    = (state_q == RESP) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = state_q != IDLE;
  assign err       = err_q;
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: table-driven vectors plus hand sequences for tie rotation, watchdog and mid-transaction reset.
module tb_lsu_arbiter;
  logic        clk = 1'b0;
  logic        reset, if_req, ls_req, ls_we, lsu_done;
  logic [7:0]  if_addr, ls_addr, lsu_addr;
  logic [15:0] ls_wdata, lsu_rdata, if_rdata, ls_rdata, lsu_wdata;
  logic        if_ack, ls_ack, busy, err;
  logic [1:0]  lsu_en;
  int checks = 0;
  int fails = 0;
  int zeros = 0;
  int last_gap = 0;

  always #5 clk = ~clk;

  lsu_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ack(ls_ack),
    .lsu_en(lsu_en), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .busy(busy), .err(err)
  );

  typedef struct {
    logic ifr; logic [7:0] ifa; logic lsr; logic we; logic [7:0] lsa; logic [15:0] lsw;
    logic [15:0] rd; logic dn;
    logic [1:0] en; logic [7:0] a; logic [15:0] w; logic ia; logic la;
    logic [15:0] ird; logic [15:0] lrd; logic bsy;
  } vec_t;
  vec_t v[20];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (lsu_en == 2'b00) zeros++;
    else if (zeros != 0) begin
      last_gap = zeros;
      zeros = 0;
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    lsu_rdata = 0; lsu_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  // both requests held: expected owner identified by its address (IF 0x01, LS 0x02)
  task automatic run_txn(input int t, input bit exp_ls);
    int n = 0;
    while (lsu_en == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("rr%0d_grant_seen", t), 16'(n < 20), 16'd1);
    chk($sformatf("rr%0d_owner_addr", t), 16'(lsu_addr), exp_ls ? 16'h02 : 16'h01);
    if (t > 0) chk($sformatf("rr%0d_gap_ge2", t), 16'(last_gap >= 2), 16'd1);
    tick();
    chk($sformatf("rr%0d_en_held", t), 16'(lsu_en), 16'h1);
    lsu_done = 1; lsu_rdata = 16'h0100 + 16'(t);
    tick();
    lsu_done = 0;
    chk($sformatf("rr%0d_if_ack", t), 16'(if_ack), exp_ls ? 16'd0 : 16'd1);
    chk($sformatf("rr%0d_ls_ack", t), 16'(ls_ack), exp_ls ? 16'd1 : 16'd0);
    chk($sformatf("rr%0d_rdata", t), exp_ls ? ls_rdata : if_rdata, 16'h0100 + 16'(t));
    chk($sformatf("rr%0d_en_resp", t), 16'(lsu_en), 16'h0);
    tick();
    chk($sformatf("rr%0d_acks_clear", t), {14'h0, if_ack, ls_ack}, 16'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    //         ifr ifa    lsr we lsa    lsw       rd        dn  en  a      w         ia la ird       lrd       bsy
    v[0]  = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0};
    v[1]  = '{1, 8'h12, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 8'h12, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1};
    v[2]  = '{1, 8'h12, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 8'h12, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1};
    v[3]  = '{1, 8'h12, 0, 0, 8'h00, 16'h0000, 16'hBEEF, 1, 0, 8'h12, 16'h0000, 1, 0, 16'hBEEF, 16'h0000, 1};
    v[4]  = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h12, 16'h0000, 0, 0, 16'hBEEF, 16'h0000, 0};
    v[5]  = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h1111, 1, 0, 8'h12, 16'h0000, 0, 0, 16'hBEEF, 16'h0000, 0};
    v[6]  = '{0, 8'h00, 1, 1, 8'h40, 16'hA5C3, 16'h0000, 0, 2, 8'h40, 16'hA5C3, 0, 0, 16'hBEEF, 16'h0000, 1};
    v[7]  = '{0, 8'h00, 1, 1, 8'h40, 16'hA5C3, 16'hDEAD, 0, 2, 8'h40, 16'hA5C3, 0, 0, 16'hBEEF, 16'h0000, 1};
    v[8]  = '{0, 8'h00, 1, 1, 8'h40, 16'hA5C3, 16'hDEAD, 1, 0, 8'h40, 16'hA5C3, 0, 1, 16'hBEEF, 16'h0000, 1};
    v[9]  = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h40, 16'hA5C3, 0, 0, 16'hBEEF, 16'h0000, 0};
    v[10] = '{0, 8'h00, 1, 0, 8'h07, 16'h0000, 16'h0000, 0, 1, 8'h07, 16'h0000, 0, 0, 16'hBEEF, 16'h0000, 1};
    v[11] = '{0, 8'h00, 1, 0, 8'h07, 16'h0000, 16'h0F0F, 1, 0, 8'h07, 16'h0000, 0, 1, 16'hBEEF, 16'h0F0F, 1};
    v[12] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h07, 16'h0000, 0, 0, 16'hBEEF, 16'h0F0F, 0};
    v[13] = '{1, 8'h21, 1, 0, 8'h33, 16'h0000, 16'h0000, 0, 1, 8'h21, 16'h0000, 0, 0, 16'hBEEF, 16'h0F0F, 1};
    v[14] = '{1, 8'h21, 1, 0, 8'h33, 16'h0000, 16'hCAFE, 1, 0, 8'h21, 16'h0000, 1, 0, 16'hCAFE, 16'h0F0F, 1};
    v[15] = '{1, 8'h21, 1, 0, 8'h33, 16'h0000, 16'h0000, 0, 0, 8'h21, 16'h0000, 0, 0, 16'hCAFE, 16'h0F0F, 0};
    v[16] = '{1, 8'h21, 1, 0, 8'h33, 16'h0000, 16'h0000, 0, 1, 8'h33, 16'h0000, 0, 0, 16'hCAFE, 16'h0F0F, 1};
    v[17] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 8'h33, 16'h0000, 0, 0, 16'hCAFE, 16'h0F0F, 1};
    v[18] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h7777, 1, 0, 8'h33, 16'h0000, 0, 1, 16'hCAFE, 16'h7777, 1};
    v[19] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h33, 16'h0000, 0, 0, 16'hCAFE, 16'h7777, 0};

    do_reset();
    chk("reset_err", 16'(err), 16'h0);
    for (int i = 0; i < 20; i++) begin
      if_req = v[i].ifr; if_addr = v[i].ifa; ls_req = v[i].lsr; ls_we = v[i].we;
      ls_addr = v[i].lsa; ls_wdata = v[i].lsw; lsu_rdata = v[i].rd; lsu_done = v[i].dn;
      tick();
      chk($sformatf("vec%0d_lsu_en", i), 16'(lsu_en), 16'(v[i].en));
      chk($sformatf("vec%0d_lsu_addr", i), 16'(lsu_addr), 16'(v[i].a));
      chk($sformatf("vec%0d_lsu_wdata", i), lsu_wdata, v[i].w);
      chk($sformatf("vec%0d_if_ack", i), 16'(if_ack), 16'(v[i].ia));
      chk($sformatf("vec%0d_ls_ack", i), 16'(ls_ack), 16'(v[i].la));
      chk($sformatf("vec%0d_if_rdata", i), if_rdata, v[i].ird);
      chk($sformatf("vec%0d_ls_rdata", i), ls_rdata, v[i].lrd);
      chk($sformatf("vec%0d_busy", i), 16'(busy), 16'(v[i].bsy));
    end
    idle_inputs();

    // reset asserted while a store is in GRANT
    ls_req = 1; ls_we = 1; ls_addr = 8'h66; ls_wdata = 16'h1357;
    tick();
    chk("mid_rst_granted", 16'(lsu_en), 16'h2);
    reset = 0;
    tick();
    chk("mid_rst_en", 16'(lsu_en), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    chk("mid_rst_acks", {14'h0, if_ack, ls_ack}, 16'h0);
    chk("mid_rst_addr", 16'(lsu_addr), 16'h0);
    chk("mid_rst_wdata", lsu_wdata, 16'h0);
    chk("mid_rst_if_rdata", if_rdata, 16'h0);
    chk("mid_rst_ls_rdata", ls_rdata, 16'h0);
    chk("mid_rst_err", 16'(err), 16'h0);
    reset = 1; ls_req = 0; ls_we = 0;
    tick();
    chk("post_rst_acks", {14'h0, if_ack, ls_ack}, 16'h0);
    chk("post_rst_busy", 16'(busy), 16'h0);

    // both requests held from reset: LS first, then alternate
    do_reset();
    zeros = 0;
    if_req = 1; ls_req = 1; if_addr = 8'h01; ls_addr = 8'h02; ls_we = 0;
    for (int t = 0; t < 4; t++) run_txn(t, (t % 2) == 0);
    idle_inputs();
    tick();

    // watchdog with TIMEOUT_CYCLES = 8
    do_reset();
    if_req = 1; if_addr = 8'h55;
    tick();
    if_req = 0;
    chk("wd_granted", 16'(lsu_en), 16'h1);
    for (int i = 0; i < 7; i++) tick();
    chk("wd_err_before", 16'(err), 16'h0);
    tick();
    chk("wd_err_set", 16'(err), 16'h1);
    chk("wd_en_kept", 16'(lsu_en), 16'h1);
    for (int i = 0; i < 3; i++) tick();
    chk("wd_still_waiting", 16'(lsu_en), 16'h1);
    lsu_done = 1; lsu_rdata = 16'h4242;
    tick();
    lsu_done = 0;
    chk("wd_late_ack", 16'(if_ack), 16'h1);
    chk("wd_late_rdata", if_rdata, 16'h4242);
    chk("wd_err_sticky_resp", 16'(err), 16'h1);
    tick();
    chk("wd_err_sticky_idle", 16'(err), 16'h1);
    chk("wd_idle_busy", 16'(busy), 16'h0);
    reset = 0;
    tick();
    reset = 1;
    chk("wd_err_cleared", 16'(err), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
